// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and types for the conv output packer
package conv_pkg;
  localparam int PIX_W  = 8;
  localparam int BUS_W  = 256;
  localparam int ADDR_W = 20;
  localparam int LANES  = BUS_W / PIX_W;
  localparam int LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} pack_state_t;
  typedef logic [BUS_W-1:0] word_t;
endpackage

// File: rtl/conv_word_fifo.sv
// rtl/conv_word_fifo.sv - synchronous word FIFO; a push into a full FIFO
// succeeds when a pop happens the same cycle
module conv_word_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/conv_out_packer.sv
// rtl/conv_out_packer.sv - packs conv_top pixels into 256-bit words and writes them out.
// Define CONV_PACK_STATS_EN to add saturating pix_count/word_count outputs.
module conv_out_packer
  import conv_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [PIX_W-1:0]  in_data,
  input  logic              in_vld,
  input  logic              conv_done,
  output logic [ADDR_W-1:0] w_addr,
  output logic [BUS_W-1:0]  w_data,
  output logic              w_en,
  input  logic              w_rdy,
  output logic              busy,
  output logic              done,
  output logic              ovf
`ifdef CONV_PACK_STATS_EN
  ,
  output logic [31:0]       pix_count,
  output logic [31:0]       word_count
`endif
);
  pack_state_t       state;
  logic [LANE_W-1:0] lane;
  word_t             acc;
  word_t             acc_next;
  word_t             fifo_head;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              last_lane;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign accept    = (state == RUN) && in_vld;
  assign last_lane = (lane == LANE_W'(LANES - 1));
  assign push_req  = (accept && last_lane) || ((state == FLUSH) && (lane != '0));
  assign pop       = !fifo_empty && w_rdy;
  assign push_ok   = push_req && (!fifo_full || pop);

  // In FLUSH no pixel is accepted, so acc_next is the zero-filled partial word.
  always_comb begin
    acc_next = acc;
    if (accept) acc_next[lane*PIX_W +: PIX_W] = in_data;
  end

  conv_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BUS_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (acc_next),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign w_en   = !fifo_empty;
  assign w_data = fifo_empty ? '0 : fifo_head;
  assign w_addr = addr;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lane  <= '0;
      acc   <= '0;
      addr  <= '0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      // Address is bound to a word when it leaves the FIFO.
      if (pop) addr <= addr + ADDR_W'(1);
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            addr  <= base_addr;
            ovf   <= 1'b0;
            lane  <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (last_lane) begin
              lane <= '0;
              acc  <= '0;
              if (!push_ok) ovf <= 1'b1;
            end else begin
              lane <= lane + LANE_W'(1);
              acc  <= acc_next;
            end
          end
          if (conv_done) state <= FLUSH;
        end
        FLUSH: begin
          if (lane != '0) begin
            if (push_ok) begin
              lane <= '0;
              acc  <= '0;
            end
          end else if (fifo_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV_PACK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || ((state == IDLE) && start)) begin
      pix_count  <= '0;
      word_count <= '0;
    end else begin
      if (accept && (pix_count != '1))  pix_count  <= pix_count + 32'd1;
      if (pop && (word_count != '1))    word_count <= word_count + 32'd1;
    end
  end
`endif
endmodule

// File: doc/conv_out_packer.md
Name: conv_out_packer

Overview:
Downstream stage of conv_top. Collects the 8-bit result pixels conv_top emits on out_data/out_rdy and packs them into 256-bit words. Writes those words back to the 20-bit word-addressed data memory, the same word size and addressing as the hb_mem read bus. Absorbs write-side stalls in a small word FIFO, because conv_top has no backpressure, and signals completion once conv_done has been flushed to memory.

Parameters:
PIX_W, 8, pixel width in bits
BUS_W, 256, memory word width; LANES = BUS_W/PIX_W = 32
ADDR_W, 20, memory word address width
FIFO_DEPTH, 2, completed-word buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse in IDLE; loads base_addr and enters RUN
base_addr  in  ADDR_W  first write word address
in_data  in  PIX_W  pixel from conv_top out_data
in_vld  in  1  pixel valid, from conv_top out_rdy
conv_done  in  1  from conv_top; no further pixels follow
w_addr  out  ADDR_W  write word address
w_data  out  BUS_W  write data
w_en  out  1  write request
w_rdy  in  1  memory accepts write this cycle
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when all words are written
ovf  out  1  sticky overflow flag, cleared by rst or start

Behaviour:
- Reset: state=IDLE. Lane counter, FIFO pointers and address are 0. w_en, w_addr, w_data, busy, done and ovf are all 0.
- Packing: pixel k of a word (k = 0..31) goes to bits [8k+7:8k], so the first pixel is the LSB byte.
- A pixel is accepted only in RUN when in_vld=1. in_vld is ignored in IDLE, FLUSH and DONE.
- On the 32nd accepted pixel, the complete word, including that pixel, is pushed into the FIFO the same cycle and the lane counter returns to 0.
- Write handshake: w_en, w_addr and w_data come from the FIFO head and are registered; w_en=1 whenever the FIFO is non-empty.
  - A transfer occurs on a cycle with w_en & w_rdy; the head is then popped and the address is incremented.
  - w_addr and w_data are held stable while w_en=1 and w_rdy=0.
- Address: starts at base_addr and increments by 1 per transfer, wrapping 2^ADDR_W-1 -> 0. The address is attached to a word at pop, not at push.
- Latency: with the FIFO empty, the 32nd pixel at cycle N gives w_en=1 at N+1.
- FIFO full plus push:
  - If a pop happens the same cycle, the push succeeds.
  - Otherwise the completed word is dropped, ovf is set to 1, and the address is not advanced for it.
- FSM:
  - IDLE -> RUN on start. start outside IDLE is ignored.
  - RUN -> FLUSH on conv_done. An in_vld pixel on the same cycle is accepted first, including a completed-word push.
  - FLUSH: if the lane counter is >0, push the partial word with unused upper lanes zero-filled. The push waits for FIFO space; nothing is dropped in FLUSH. Then wait for the FIFO to empty.
  - FLUSH -> DONE when the FIFO is empty and no partial word is pending.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- conv_done outside RUN is ignored.
- rst mid-operation: next edge returns to reset state. Partial and buffered words are discarded, and w_en=0 from that edge.

Optional Feature:
Macro: CONV_PACK_STATS_EN.
- Defined: adds outputs pix_count[31:0] (accepted pixels) and word_count[31:0] (completed write transfers). Both are cleared by rst and start and are saturating.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Shared package conv_pkg holds:
  - PIX_W/BUS_W/ADDR_W constants and LANES
  - typedef pack_state_t {IDLE, RUN, FLUSH, DONE}
  - typedef word_t logic[BUS_W-1:0]
- One natural sub-module is conv_word_fifo: a parameterised synchronous FIFO with push/pop/full/empty and simultaneous push+pop allowed when full.

Test Plan:
- Full word: base 0x00100, w_rdy=1, pixels 0x00..0x1F, then conv_done. Expect one write at 0x00100 with w_data byte0=0x00 ... byte31=0x1F, then a done pulse and ovf=0.
- Partial flush: base 0x00020, 5 pixels 0xA1..0xA5, conv_done. Expect one write at 0x00020 with bytes0..4 = A1..A5 and all other bytes 0.
- Backpressure: w_rdy=0, 96 consecutive pixels, then w_rdy=1. Expect 2 writes at base and base+1 holding words 0 and 1, ovf=1, and word 2 lost.
- Wrap: base 0xFFFFF, 64 pixels, w_rdy=1. Expect writes at 0xFFFFF then 0x00000.
- Simultaneous: the 32nd pixel arrives with conv_done in the same cycle. Expect exactly one write, no zero-padded extra word, and done follows.
- Reset mid-run: after 40 pixels with w_rdy=0, pulse rst. Expect all outputs 0 next cycle and no write afterwards. A new start then writes correctly from the new base_addr.
